dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
//==============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for the MEM-stage load/store port.
//               Accepts one request at a time over valid/ready, waits
//               WAIT_CYCLES extra cycles, commits stores with byte-lane
//               enables and returns right-aligned, zero-extended load data.
// Ports       : clk, rst_n          - clock, async active-low reset
//               req_valid/req_ready - request handshake
//               req_we, req_len     - store flag, size (00 B, 01 H, 10 W)
//               req_addr, req_wdata - byte address, right-aligned store data
//               resp_valid          - one-cycle response strobe
//               resp_rdata/resp_err - load data / rejection flag
//               busy                - high while a request is in flight
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [3:0]  c_wait  = 4'(WAIT_CYCLES);
    localparam logic [29:0] c_depth = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;

    logic        r_we;
    logic [1:0]  r_len;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_commit;
    logic        w_we;
    logic [1:0]  w_len;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_err;
    logic [ADDR_BITS-1:0] w_idx;
    logic [3:0]  w_be;
    logic [31:0] w_lane;
    logic [31:0] w_rd_word;
    logic [31:0] w_load;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // ---------------------------------------------------------------------
    // FSM: state register and next-state / output decode
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = (c_wait == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                busy        = 1'b1;
                resp_valid  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Edge that enters RESP: this is where the array is read or written.
    assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

    // ---------------------------------------------------------------------
    // Wait counter and request capture
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_len   <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_cnt   <= c_wait;
            r_we    <= req_we;
            r_len   <= req_len;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end else if (r_state == S_WAIT) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // With zero wait states the accept edge is also the RESP entry edge, so
    // the fields are taken straight from the request bus in IDLE.
    assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_len   = (r_state == S_IDLE) ? req_len   : r_len;
    assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_err = (w_len == 2'b11)
                 || ((w_len == 2'b01) && w_addr[0])
                 || ((w_len == 2'b10) && (w_addr[1:0] != 2'b00))
                 || (w_addr[31:2] >= c_depth);

    assign w_idx = w_addr[ADDR_BITS+1:2];

    // ---------------------------------------------------------------------
    // Store lane enables and replicated write data
    // ---------------------------------------------------------------------
    always_comb begin
        w_be   = 4'b0000;
        w_lane = w_wdata;
        case (w_len)
            2'b00: begin
                w_be   = 4'b0001 << w_addr[1:0];
                w_lane = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lane = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_be   = 4'b1111;
                w_lane = w_wdata;
            end
            default: begin
                w_be   = 4'b0000;
                w_lane = w_wdata;
            end
        endcase
    end

    // rst_n gates the commit so a request sampled while reset is held
    // can never reach the array.
    assign w_commit = rst_n && w_enter_resp && w_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) begin
                    r_mem[w_idx][l*8 +: 8] <= w_lane[l*8 +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Load path: right-aligned, zero-extended
    // ---------------------------------------------------------------------
    assign w_rd_word = r_mem[w_idx];

    always_comb begin
        w_load = 32'd0;
        case (w_len)
            2'b00:   w_load = {24'd0, w_rd_word[{w_addr[1:0], 3'b000} +: 8]};
            2'b01:   w_load = {16'd0, (w_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0])};
            2'b10:   w_load = w_rd_word;
            default: w_load = 32'd0;
        endcase
    end

    // Response registers update only on RESP entry and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_rdata <= (w_we || w_err) ? 32'd0 : w_load;
            r_err   <= w_err;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//==============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder. Four
//               instances with WAIT_CYCLES = 2, 0, 5, 1 share the request
//               fields; each has its own req_valid and response outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_we;
    logic [1:0]  req_len;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        vld [4];
    logic        rdy [4];
    logic        rv  [4];
    logic        er  [4];
    logic        bsy [4];
    logic [31:0] rd  [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // index 0: WAIT=2, 1: WAIT=0, 2: WAIT=5, 3: WAIT=1
    dmem_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_we(req_we), .req_len(req_len), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(er[0]), .busy(bsy[0]));
    dmem_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_we(req_we), .req_len(req_len), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(er[1]), .busy(bsy[1]));
    dmem_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .WAIT_CYCLES(5)) u_dut_w5 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_we(req_we), .req_len(req_len), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_err(er[2]), .busy(bsy[2]));
    dmem_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[3]), .req_ready(rdy[3]),
        .req_we(req_we), .req_len(req_len), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[3]), .resp_rdata(rd[3]), .resp_err(er[3]), .busy(bsy[3]));

    // Response capture for the back-to-back run on the WAIT=1 instance.
    int          b2b_n = 0;
    logic [31:0] b2b_rd [8];
    always @(negedge clk) begin
        if (rv[3] && b2b_n < 8) begin
            b2b_rd[b2b_n] = rd[3];
            b2b_n = b2b_n + 1;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction; returns data, error, accept-to-resp_valid
    // latency and the number of post-accept cycles with req_ready low.
    task automatic xact(input int d, input logic we, input logic [1:0] len,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdo, output logic erro,
                        output int lat, output int rlo);
        int n;
        @(negedge clk);
        req_we = we; req_len = len; req_addr = a; req_wdata = wd;
        vld[d] = 1'b1;
        n = 0;
        while (!rdy[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) chk_eq("accept_timeout", 32'(rdy[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        vld[d] = 1'b0;
        lat = 1;
        rlo = rdy[d] ? 0 : 1;
        while (!rv[d] && lat < 50) begin
            @(negedge clk);
            lat++;
            if (!rdy[d]) rlo++;
        end
        if (!rv[d]) chk_eq("resp_timeout", 32'(rv[d]), 32'd1);
        rdo  = rd[d];
        erro = er[d];
        @(negedge clk);
        chk_eq("ready_back", 32'(rdy[d]), 32'd1);
    endtask

    task automatic do_st(input int d, input logic [1:0] len, input logic [31:0] a,
                         input logic [31:0] wd, input logic eerr, input string tag);
        logic [31:0] r; logic e; int l; int q;
        xact(d, 1'b1, len, a, wd, r, e, l, q);
        chk_eq({tag, "_err"}, 32'(e), 32'(eerr));
        chk_eq({tag, "_rd"}, r, 32'd0);
    endtask

    task automatic do_ld(input int d, input logic [1:0] len, input logic [31:0] a,
                         input logic [31:0] exp, input logic eerr, input string tag);
        logic [31:0] r; logic e; int l; int q;
        xact(d, 1'b0, len, a, 32'd0, r, e, l, q);
        chk_eq({tag, "_err"}, 32'(e), 32'(eerr));
        chk_eq({tag, "_rd"}, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat, rlo, n, cnt;
        time         acc [4];

        for (int i = 0; i < 4; i++) vld[i] = 1'b0;
        req_we = 1'b0; req_len = 2'b00; req_addr = 32'd0; req_wdata = 32'd0;

        // Reset values
        repeat (3) @(negedge clk);
        chk_eq("rst_ready", 32'(rdy[0]), 32'd1);
        chk_eq("rst_rvalid", 32'(rv[0]), 32'd0);
        chk_eq("rst_rdata", rd[0], 32'd0);
        chk_eq("rst_err", 32'(er[0]), 32'd0);
        chk_eq("rst_busy", 32'(bsy[0]), 32'd0);
        rst_n = 1'b1;

        // Word store then load, WAIT=2
        xact(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, r, e, lat, rlo);
        chk_eq("st10_lat", 32'(lat), 32'd3);
        chk_eq("st10_rlo", 32'(rlo), 32'd3);
        chk_eq("st10_err", 32'(e), 32'd0);
        chk_eq("st10_rd", r, 32'd0);
        do_ld(0, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, "ld10");

        // Byte / half lanes
        do_st(0, 2'b10, 32'h20, 32'h00000000, 1'b0, "st20w");
        do_st(0, 2'b00, 32'h22, 32'h000000AB, 1'b0, "st22b");
        do_st(0, 2'b01, 32'h20, 32'h00001234, 1'b0, "st20h");
        do_ld(0, 2'b10, 32'h20, 32'h00AB1234, 1'b0, "ld20w");
        do_ld(0, 2'b00, 32'h22, 32'h000000AB, 1'b0, "ld22b");
        do_ld(0, 2'b01, 32'h22, 32'h000000AB, 1'b0, "ld22h");
        do_ld(0, 2'b00, 32'h20, 32'h00000034, 1'b0, "ld20b");

        // Errors
        do_st(0, 2'b10, 32'h24, 32'hCAFEF00D, 1'b0, "st24w");
        do_st(0, 2'b10, 32'h00, 32'h01020304, 1'b0, "st00w");
        do_ld(0, 2'b10, 32'h24, 32'hCAFEF00D, 1'b0, "ld24_pre");
        do_ld(0, 2'b01, 32'h21, 32'h0, 1'b1, "err_ldh21");
        do_st(0, 2'b10, 32'h26, 32'h99999999, 1'b1, "err_stw26");
        do_st(0, 2'b11, 32'h24, 32'h77777777, 1'b1, "err_len11");
        do_ld(0, 2'b00, 32'h20, 32'h00000034, 1'b0, "ld20b_pre");
        do_ld(0, 2'b11, 32'h20, 32'h0, 1'b1, "err_ld11");
        do_st(0, 2'b10, 32'h400, 32'h88888888, 1'b1, "err_st_oob");
        do_ld(0, 2'b10, 32'h400, 32'h0, 1'b1, "err_ld_oob");
        do_ld(0, 2'b10, 32'h20, 32'h00AB1234, 1'b0, "ld20_post");
        do_ld(0, 2'b10, 32'h24, 32'hCAFEF00D, 1'b0, "ld24_post");
        do_ld(0, 2'b10, 32'h00, 32'h01020304, 1'b0, "ld00_post");

        // Latency sweep
        xact(1, 1'b1, 2'b10, 32'h08, 32'h12345678, r, e, lat, rlo);
        chk_eq("w0_lat", 32'(lat), 32'd1);
        chk_eq("w0_rlo", 32'(rlo), 32'd1);
        do_ld(1, 2'b10, 32'h08, 32'h12345678, 1'b0, "w0_ld");
        xact(2, 1'b1, 2'b10, 32'h0C, 32'h87654321, r, e, lat, rlo);
        chk_eq("w5_lat", 32'(lat), 32'd6);
        chk_eq("w5_rlo", 32'(rlo), 32'd6);
        do_ld(2, 2'b10, 32'h0C, 32'h87654321, 1'b0, "w5_ld");

        // Reset mid-WAIT
        do_st(0, 2'b10, 32'h30, 32'h11111111, 1'b0, "st30_old");
        @(negedge clk);
        req_we = 1'b1; req_len = 2'b10; req_addr = 32'h30; req_wdata = 32'h55555555;
        vld[0] = 1'b1;
        n = 0;
        while (!rdy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        chk_eq("midw_busy", 32'(bsy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_eq("midw_rst_ready", 32'(rdy[0]), 32'd1);
        chk_eq("midw_rst_busy", 32'(bsy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv[0]) cnt++;
        end
        chk_eq("midw_no_resp", 32'(cnt), 32'd0);
        chk_eq("midw_ready", 32'(rdy[0]), 32'd1);
        do_ld(0, 2'b10, 32'h30, 32'h11111111, 1'b0, "midw_ld30");

        // Back-to-back with req_valid held high, WAIT=1
        @(negedge clk);
        vld[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_we    = (i % 2 == 0);
            req_len   = 2'b10;
            req_addr  = (i < 2) ? 32'h40 : 32'h44;
            req_wdata = (i < 2) ? 32'hA5A50001 : 32'h5A5A0002;
            n = 0;
            while (!rdy[3] && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!rdy[3]) chk_eq("b2b_accept_timeout", 32'(rdy[3]), 32'd1);
            @(posedge clk);
            acc[i] = $time;
            @(negedge clk);
        end
        vld[3] = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 1; i < 4; i++) begin
            chk_eq($sformatf("b2b_spacing%0d", i), 32'((acc[i] - acc[i-1]) / 10), 32'd3);
        end
        chk_eq("b2b_pulses", 32'(b2b_n), 32'd4);
        chk_eq("b2b_st0_rd", b2b_rd[0], 32'd0);
        chk_eq("b2b_ld1_rd", b2b_rd[1], 32'hA5A50001);
        chk_eq("b2b_ld3_rd", b2b_rd[3], 32'h5A5A0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
